// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU/loader requesters, the data BRAM and the port arbiter.
// The slave modport is the arbiter side; the master modport is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_lock;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              cpu_stall;
  logic              addr_err;
  logic              lock_timeout;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  l_req, l_we, l_addr, l_wdata, l_lock,
    input  mem_rdata,
    output c_gnt, c_rvalid, c_rdata,
    output l_gnt, l_rvalid, l_rdata,
    output mem_addr, mem_we, mem_wdata,
    output cpu_stall, addr_err, lock_timeout
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output l_req, l_we, l_addr, l_wdata, l_lock,
    output mem_rdata,
    input  c_gnt, c_rvalid, c_rdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  mem_addr, mem_we, mem_wdata,
    input  cpu_stall, addr_err, lock_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port data BRAM between the CPU (C) and the
// UART loader (L), with a loader burst lock bounded by a forced CPU grant.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int NUM_BYTES = 800,
  parameter int LOCK_MAX  = 64,
  parameter int DATA_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_C, OWN_L} owner_e;
  typedef enum logic {WIN_C, WIN_L} winner_e;

  winner_e           last_winner;
  logic              lock_owned;
  logic [CNT_W-1:0]  lock_cnt;
  logic              lock_timeout_q;
  logic [ADDR_W-1:0] addr_hold;
  owner_e            rd_owner_p1;
  logic              rd_err_p1;

  logic              both_req, lock_act, force_c, lock_nxt;
  logic              c_gnt, l_gnt, gnt;
  logic              sel_we, in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              c_rvalid, l_rvalid;

  // The last full word must fit below NUM_BYTES.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return a <= ADDR_W'(NUM_BYTES - 4);
  endfunction

  always_comb begin
    both_req = bus.c_req & bus.l_req;
    lock_act = lock_owned & bus.l_lock;
    force_c  = both_req & lock_act & (lock_cnt == CNT_W'(LOCK_MAX));
    c_gnt    = 1'b0;
    l_gnt    = 1'b0;
    if (!reset) begin
      if (both_req) begin
        if (lock_act) begin
          c_gnt = force_c;
          l_gnt = ~force_c;
        end else begin
          c_gnt = (last_winner == WIN_L);
          l_gnt = (last_winner == WIN_C);
        end
      end else begin
        c_gnt = bus.c_req;
        l_gnt = bus.l_req;
      end
    end
    gnt       = c_gnt | l_gnt;
    sel_addr  = l_gnt ? bus.l_addr  : bus.c_addr;
    sel_we    = l_gnt ? bus.l_we    : bus.c_we;
    sel_wdata = l_gnt ? bus.l_wdata : bus.c_wdata;
    in_range  = addr_in_range(sel_addr);
    lock_nxt  = bus.l_lock & (lock_owned | l_gnt);
  end

  assign c_rvalid         = ~reset & (rd_owner_p1 == OWN_C);
  assign l_rvalid         = ~reset & (rd_owner_p1 == OWN_L);
  assign bus.c_gnt        = c_gnt;
  assign bus.l_gnt        = l_gnt;
  assign bus.c_rvalid     = c_rvalid;
  assign bus.l_rvalid     = l_rvalid;
  assign bus.c_rdata      = (c_rvalid & ~rd_err_p1) ? bus.mem_rdata : '0;
  assign bus.l_rdata      = (l_rvalid & ~rd_err_p1) ? bus.mem_rdata : '0;
  assign bus.mem_addr     = gnt ? sel_addr : addr_hold;
  assign bus.mem_we       = gnt & sel_we & in_range;
  assign bus.mem_wdata    = gnt ? sel_wdata : '0;
  assign bus.addr_err     = gnt & ~in_range;
  assign bus.cpu_stall    = ~reset & bus.c_req & ~c_gnt;
  assign bus.lock_timeout = lock_timeout_q;

  // Grant edge -> read-return stage (_p1)
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner    <= WIN_L;
      lock_owned     <= 1'b0;
      lock_cnt       <= '0;
      lock_timeout_q <= 1'b0;
      addr_hold      <= '0;
      rd_owner_p1    <= OWN_NONE;
      rd_err_p1      <= 1'b0;
    end else begin
      if (gnt) begin
        last_winner <= l_gnt ? WIN_L : WIN_C;
        addr_hold   <= sel_addr;
      end
      lock_owned <= lock_nxt;
      if (c_gnt || !lock_nxt) begin
        lock_cnt <= '0;
      end else if (l_gnt && lock_act && bus.c_req) begin
        lock_cnt <= lock_cnt + CNT_W'(1);
      end
      if (force_c) begin
        lock_timeout_q <= 1'b1;
      end
      if (gnt && !sel_we) begin
        rd_owner_p1 <= l_gnt ? OWN_L : OWN_C;
      end else begin
        rd_owner_p1 <= OWN_NONE;
      end
      rd_err_p1 <= gnt & ~sel_we & ~in_range;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for multi-cycle corners,
// and constrained-random traffic checked every cycle against a behavioural model.
module tb_mem_port_arbiter;

  localparam int LOCK_MAX  = 4;
  localparam int NUM_BYTES = 800;

  logic clk = 1'b0;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .NUM_BYTES(NUM_BYTES), .LOCK_MAX(LOCK_MAX), .DATA_W(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 + 32'(i);
  endfunction

  // Behavioural BRAM: 1-cycle registered read, contents restored on reset.
  logic [31:0] bram [0:255];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) bram[i] <= init_word(i);
    end else if (bus.mem_we && bus.mem_addr < 32'(NUM_BYTES)) begin
      bram[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= (bus.mem_addr < 32'(NUM_BYTES)) ? bram[bus.mem_addr[9:2]] : 32'hBAD0_BAD0;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model state
  int          m_lw;      // last winner: 1=C, 2=L
  bit          m_lock;
  int          m_cnt;
  int          m_pend;    // 0 none, 1 C, 2 L
  logic [31:0] m_pdata;
  logic [31:0] m_last;
  bit          m_ts;
  bit          known = 1'b0;
  logic [31:0] mm [0:255];

  // Inputs and model decision sampled for the current cycle
  int          g;
  logic [31:0] ga, gwd;
  bit          gwe, inr, forced, s_reset, s_creq, s_llock;

  // Observed outputs of the current cycle
  logic        o_cg, o_lg, o_crv, o_lrv, o_we, o_err, o_ts;
  logic [31:0] o_crd, o_lrd;

  task automatic tick();
    @(negedge clk);
    s_reset = reset;
    s_creq  = bus.c_req;
    s_llock = bus.l_lock;
    forced  = 1'b0;
    if (s_reset) g = 0;
    else if (bus.c_req && bus.l_req) begin
      if (m_lock && bus.l_lock) begin
        g = (m_cnt == LOCK_MAX) ? 1 : 2;
        forced = (m_cnt == LOCK_MAX);
      end else g = (m_lw == 2) ? 1 : 2;
    end else if (bus.c_req) g = 1;
    else if (bus.l_req) g = 2;
    else g = 0;
    ga  = (g == 2) ? bus.l_addr  : bus.c_addr;
    gwd = (g == 2) ? bus.l_wdata : bus.c_wdata;
    gwe = (g == 2) ? bus.l_we    : bus.c_we;
    inr = (ga <= 32'(NUM_BYTES - 4));

    o_cg = bus.c_gnt;   o_lg = bus.l_gnt;
    o_crv = bus.c_rvalid; o_lrv = bus.l_rvalid;
    o_crd = bus.c_rdata;  o_lrd = bus.l_rdata;
    o_we = bus.mem_we;  o_err = bus.addr_err; o_ts = bus.lock_timeout;

    if (known) begin
      check("model c_gnt", o_cg, (g == 1));
      check("model l_gnt", o_lg, (g == 2));
      check("model cpu_stall", bus.cpu_stall, (!s_reset && s_creq && g != 1));
      check("model mem_we", o_we, (g != 0 && gwe && inr));
      check("model addr_err", o_err, (g != 0 && !inr));
      check("model mem_addr", bus.mem_addr, (g != 0) ? ga : m_last);
      check("model mem_wdata", bus.mem_wdata, (g != 0) ? gwd : 32'h0);
      check("model c_rvalid", o_crv, (!s_reset && m_pend == 1));
      check("model l_rvalid", o_lrv, (!s_reset && m_pend == 2));
      check("model c_rdata", o_crd, (!s_reset && m_pend == 1) ? m_pdata : 32'h0);
      check("model l_rdata", o_lrd, (!s_reset && m_pend == 2) ? m_pdata : 32'h0);
      check("model lock_timeout", o_ts, m_ts);
    end

    @(posedge clk);
    if (s_reset) begin
      m_lw = 2; m_lock = 0; m_cnt = 0; m_pend = 0; m_pdata = 0; m_last = 0; m_ts = 0;
      known = 1'b1;
      for (int i = 0; i < 256; i++) mm[i] = init_word(i);
    end else begin
      m_pend = 0;
      m_pdata = 0;
      if (g != 0) begin
        if (!gwe) begin
          m_pend  = g;
          m_pdata = inr ? mm[ga[9:2]] : 32'h0;
        end else if (inr) mm[ga[9:2]] = gwd;
        m_lw   = g;
        m_last = ga;
      end
      if (forced) m_ts = 1'b1;
      if (g == 1) m_cnt = 0;
      else if (g == 2 && m_lock && s_llock && s_creq) m_cnt++;
      if (!s_llock) m_lock = 0;
      else if (g == 2) m_lock = 1;
      if (!m_lock) m_cnt = 0;
    end
    #1;
  endtask

  task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                       input bit lr, input bit lw, input logic [31:0] la, input logic [31:0] ld,
                       input bit lk);
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
    bus.l_req = lr; bus.l_we = lw; bus.l_addr = la; bus.l_wdata = ld; bus.l_lock = lk;
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 15) == 0) return 32'd797 + $urandom_range(0, 400);
    return $urandom_range(0, 199) * 4;
  endfunction

  typedef struct {
    bit cr, lr, lk;
    bit ecg, elg, ecrv, elrv, ets;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reads at 0x10 (C) and 0x20 (L); lock burst with LOCK_MAX=4
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 5; i <= 8; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 11; i <= 13; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b1;
    drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset c_gnt", o_cg, 0);
      check("reset l_gnt", o_lg, 0);
      check("reset rvalid", {o_crv, o_lrv}, 0);
      check("reset mem_we", o_we, 0);
    end
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].cr, 0, 32'h10, 32'h0, tbl[i].lr, 0, 32'h20, 32'h0, tbl[i].lk);
      tick();
      check($sformatf("vec%0d c_gnt", i), o_cg, tbl[i].ecg);
      check($sformatf("vec%0d l_gnt", i), o_lg, tbl[i].elg);
      check($sformatf("vec%0d c_rvalid", i), o_crv, tbl[i].ecrv);
      check($sformatf("vec%0d l_rvalid", i), o_lrv, tbl[i].elrv);
      check($sformatf("vec%0d c_rdata", i), o_crd, tbl[i].ecrv ? 32'hA500_0004 : 32'h0);
      check($sformatf("vec%0d l_rdata", i), o_lrd, tbl[i].elrv ? 32'hA500_0008 : 32'h0);
      check($sformatf("vec%0d lock_timeout", i), o_ts, tbl[i].ets);
    end
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    tick();

    // Write by C, read back by L
    drive(1, 1, 32'h40, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0, 0);
    tick();
    check("wr c_gnt", o_cg, 1);
    check("wr mem_we", o_we, 1);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0, 0);
    tick();
    check("rd l_gnt", o_lg, 1);
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    tick();
    check("rd l_rvalid", o_lrv, 1);
    check("rd l_rdata", o_lrd, 32'hDEAD_BEEF);
    check("rd c_rvalid", o_crv, 0);

    // Out-of-range write and read
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'd800, 32'h1234_5678, 0);
    tick();
    check("oor wr l_gnt", o_lg, 1);
    check("oor wr mem_we", o_we, 0);
    check("oor wr addr_err", o_err, 1);
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    tick();
    check("oor err pulse", o_err, 0);
    check("oor wr no rvalid", o_lrv, 0);
    drive(1, 0, 32'd1000, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    tick();
    check("oor rd addr_err", o_err, 1);
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    tick();
    check("oor rd c_rvalid", o_crv, 1);
    check("oor rd c_rdata", o_crd, 32'h0);

    // Reset arriving while a read is in flight
    drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    tick();
    check("midrst c_gnt", o_cg, 1);
    reset = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    tick();
    check("midrst c_rvalid during reset", o_crv, 0);
    reset = 1'b0;
    tick();
    check("midrst c_rvalid after reset", o_crv, 0);
    check("midrst lock_timeout cleared", o_ts, 0);

    // Random traffic; requesters hold their request until granted
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!(bus.c_req && !o_cg)) begin
        bus.c_req = ($urandom_range(0, 2) != 0);
        bus.c_we = $urandom_range(0, 1);
        bus.c_addr = rnd_addr();
        bus.c_wdata = $urandom();
      end
      if (!(bus.l_req && !o_lg)) begin
        bus.l_req = ($urandom_range(0, 2) != 0);
        bus.l_we = $urandom_range(0, 1);
        bus.l_addr = rnd_addr();
        bus.l_wdata = $urandom();
      end
      if ($urandom_range(0, 7) == 0) bus.l_lock = ~bus.l_lock;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
